// File: rtl/snake_disp_pkg.sv
// snake_disp_pkg: shared constants and types for the score display path
package snake_disp_pkg;
  localparam int NUM_DIGITS = 4;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam logic [3:0] ALL_OFF = 4'b1111;
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade counter stage with ripple carry out
module bcd_digit
  import snake_disp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc_in,
  output bcd_t digit,
  output logic carry_out
);
  bcd_t digit_q, digit_d;
  always_comb digit_d = clr ? '0 : !inc_in ? digit_q : (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
  always_ff @(posedge clk)
    if (rst) digit_q <= '0;
    else digit_q <= digit_d;
  assign digit = digit_q;
  assign carry_out = inc_in && (digit_q == BCD_MAX);
endmodule

// File: rtl/score_scan_driver.sv
// score_scan_driver: saturating 4-digit BCD score with multiplexed digit scan
module score_scan_driver
  import snake_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        score_inc,
  input  logic        score_clr,
  output logic [3:0]  num,
  output logic [3:0]  digit_en,
  output logic [15:0] score_bcd,
  output logic        saturated
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  bcd_t d [NUM_DIGITS];
  logic [NUM_DIGITS:0] c;
  logic full, wrap, blank, sat_q, sat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] num_q, num_d, en_q, en_d;
  assign score_bcd = {d[3], d[2], d[1], d[0]};
  assign full = (score_bcd == 16'h9999);
  assign c[0] = score_inc && !full;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk(clk), .rst(rst), .clr(score_clr), .inc_in(c[i]),
      .digit(d[i]), .carry_out(c[i+1])
    );
  end
  // Registered flag must rise together with score_bcd, so it predicts the next score.
  always_comb begin
    sat_d = !score_clr && (full || c[NUM_DIGITS] || (score_bcd == 16'h9998 && c[0]));
    wrap = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 2'd1 : idx_q;
    blank = (LZ_BLANK != 0) && (idx_d != 2'd0) && ((score_bcd >> {idx_d, 2'b00}) == 16'h0000);
    num_d = blank ? 4'd0 : d[idx_d];
    en_d = blank ? ALL_OFF : ~(4'b0001 << idx_d);
  end
  // Display registers follow the slot being entered so num/digit_en never lag the scan.
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      num_q <= '0;
      en_q  <= 4'b1110;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      num_q <= num_d;
      en_q  <= en_d;
      sat_q <= sat_d;
    end
  assign num = num_q;
  assign digit_en = en_q;
  assign saturated = sat_q;
endmodule

// File: tb/tb_score_scan_driver.sv
// tb_score_scan_driver: directed checks of score, saturation, blanking and scan timing
module tb_score_scan_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic score_inc = 1'b0;
  logic score_clr = 1'b0;
  logic [3:0] b_num, b_en, n_num, n_en;
  logic [15:0] b_score, n_score;
  logic b_sat, n_sat;
  int vectors = 0;
  int errors = 0;
  int k = 0;
  logic [3:0] en_b_tab [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
  logic [3:0] num_b_tab [4] = '{4'd2, 4'd1, 4'd0, 4'd0};
  logic [3:0] en_n_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  score_scan_driver #(.SCAN_DIV(4), .LZ_BLANK(1)) u_b (
    .clk(clk), .rst(rst), .score_inc(score_inc), .score_clr(score_clr),
    .num(b_num), .digit_en(b_en), .score_bcd(b_score), .saturated(b_sat)
  );
  score_scan_driver #(.SCAN_DIV(4), .LZ_BLANK(0)) u_n (
    .clk(clk), .rst(rst), .score_inc(score_inc), .score_clr(score_clr),
    .num(n_num), .digit_en(n_en), .score_bcd(n_score), .saturated(n_sat)
  );

  task automatic tick();
    @(posedge clk);
    k = rst ? 0 : k + 1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_en", 16'(b_en), 16'hE);
    chk("rst_num", 16'(b_num), 16'h0);
    chk("rst_score", b_score, 16'h0000);
    chk("rst_sat", 16'(b_sat), 16'h0);
    chk("rst_en_n", 16'(n_en), 16'hE);
    score_inc = 1'b1;
    repeat (12) tick();
    score_inc = 1'b0;
    chk("inc12_score", b_score, 16'h0012);
    while (k % 16 != 0) tick();
    repeat (16) begin
      tick();
      chk("blank_en", 16'(b_en), 16'(en_b_tab[(k / 4) % 4]));
      chk("blank_num", 16'(b_num), 16'(num_b_tab[(k / 4) % 4]));
      chk("noblank_en", 16'(n_en), 16'(en_n_tab[(k / 4) % 4]));
      chk("noblank_num", 16'(n_num), 16'(num_b_tab[(k / 4) % 4]));
    end
    score_clr = 1'b1;
    tick();
    score_clr = 1'b0;
    chk("clr_score", b_score, 16'h0000);
    score_inc = 1'b1;
    repeat (99) tick();
    score_inc = 1'b0;
    chk("pre_ripple", b_score, 16'h0099);
    score_inc = 1'b1;
    tick();
    score_inc = 1'b0;
    chk("ripple", b_score, 16'h0100);
    score_inc = 1'b1;
    repeat (9898) tick();
    score_inc = 1'b0;
    chk("at_9998", b_score, 16'h9998);
    chk("sat_9998", 16'(b_sat), 16'h0);
    score_inc = 1'b1;
    tick();
    chk("at_9999", b_score, 16'h9999);
    chk("sat_rise", 16'(b_sat), 16'h1);
    repeat (3) begin
      tick();
      chk("hold_9999", b_score, 16'h9999);
      chk("hold_sat", 16'(b_sat), 16'h1);
    end
    score_inc = 1'b0;
    score_clr = 1'b1;
    tick();
    score_clr = 1'b0;
    chk("sat_clr_score", b_score, 16'h0000);
    chk("sat_clr_flag", 16'(b_sat), 16'h0);
    score_inc = 1'b1;
    repeat (457) tick();
    chk("at_0457", b_score, 16'h0457);
    score_clr = 1'b1;
    tick();
    score_inc = 1'b0;
    score_clr = 1'b0;
    chk("inc_clr", b_score, 16'h0000);
    chk("inc_clr_n", n_score, 16'h0000);
    score_inc = 1'b1;
    repeat (5) tick();
    score_inc = 1'b0;
    while ((k / 4) % 4 != 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_en", 16'(n_en), 16'hE);
    chk("mid_rst_num", 16'(n_num), 16'h0);
    chk("mid_rst_score", n_score, 16'h0000);
    repeat (3) begin
      tick();
      chk("slot0_hold", 16'(n_en), 16'hE);
    end
    tick();
    chk("slot1_n", 16'(n_en), 16'hD);
    chk("slot1_b", 16'(b_en), 16'hF);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/score_scan_driver.md
SCORE_SCAN_DRIVER -- requirements
Module: score_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit scan slot; minimum 1.
REQ-002 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 shows all four digits.
REQ-003 Port clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous and active-high.
REQ-005 Port score_inc  input  1  single-cycle pulse that adds 1 to the score.
REQ-006 Port score_clr  input  1  single-cycle pulse that clears the score to 0000.
REQ-007 Port num  output  4  BCD value of the currently scanned digit; feeds the 7-segment decoder.
REQ-008 Port digit_en  output  4  active-low digit enables; at most one bit is low.
REQ-009 Port score_bcd  output  16  packed BCD score, thousands digit in [15:12].
REQ-010 Port saturated  output  1  high while the score equals 9999.

Function
REQ-011 The score SHALL be held as four BCD digits (d0 = ones ... d3 = thousands), each in the range 0-9.
REQ-012 score_clr SHALL load 0000 on the next edge, with priority over a score_inc in the same cycle.
REQ-013 score_inc without score_clr SHALL add 1 with decimal carry rippling through all digits in one cycle; the result is visible on score_bcd the next cycle.
REQ-014 At 9999, score_inc SHALL leave the score unchanged, and saturated SHALL stay 1 until a clear or reset.
REQ-015 Prescaler behaviour SHALL be as follows.
- Counts 0 to SCAN_DIV-1, then wraps to 0.
- On each wrap, digit index idx advances 0->1->2->3->0.
- With SCAN_DIV=1, idx advances every cycle.
REQ-016 num and digit_en SHALL be registered, updated in the same cycle as each other, and always correspond to the same idx.
REQ-017 num SHALL equal digit d[idx] of the current score, and digit_en SHALL be ~(1<<idx) unless the digit is blanked.
REQ-018 With LZ_BLANK=1, a digit idx>0 SHALL be blanked when it and all higher digits are 0.
- Blanked means digit_en = 1111 and num = 0.
- d0 is never blanked.
REQ-019 A score change SHALL not reset the scan; the next registered num reflects the new score.
REQ-020 saturated SHALL be registered and asserted in the same cycle that score_bcd first shows 9999.

Reset
REQ-021 While rst is high at an edge, the block SHALL load the following values, overriding score_inc and score_clr:
- score 0000 and saturated 0;
- prescaler 0 and idx 0;
- num 0 and digit_en 1110.
REQ-022 Reset asserted mid-scan or mid-increment SHALL leave no residual carry or partially advanced slot; the scan restarts from digit 0 with a full SCAN_DIV slot.

Structure
REQ-023 Shared package snake_disp_pkg SHALL hold the following:
- NUM_DIGITS = 4;
- the 4-bit BCD digit typedef;
- the BCD_MAX = 9 constant;
- the active-low enable constant ALL_OFF = 4'b1111.
REQ-024 A sub-module bcd_digit SHALL implement one decade stage with inputs clk, rst, clr, inc_in and outputs digit[3:0], carry_out (inc_in and digit == 9).
- score_scan_driver instantiates four bcd_digit stages.
- Increments are gated at saturation.
REQ-025 The 7-segment decoder SHALL remain a separate downstream block and is not instantiated here.

Verification
REQ-026 Reset check:
- Stimulus: assert rst for 2 cycles, then release.
- Required response: digit_en = 1110, num = 0, score_bcd = 16'h0000, saturated = 0.
REQ-027 Blanked scan check:
- Stimulus: SCAN_DIV=4, LZ_BLANK=1, apply 12 score_inc pulses.
- Required response: score_bcd = 16'h0012.
- Slots cycle (digit_en, num) = (1110,2), (1101,1), (1111,0), (1111,0), each slot held 4 cycles.
REQ-028 Carry ripple check:
- Stimulus: from 0099, one score_inc.
- Required response: score_bcd = 16'h0100 on the next cycle, with no intermediate value visible.
REQ-029 Saturation check:
- Stimulus: increment to 9999, then three more score_inc pulses.
- Required response: score_bcd stays 16'h9999 and saturated = 1; after a score_clr pulse, 0000 and saturated = 0.
REQ-030 Simultaneous inc/clr check:
- Stimulus: at 0457, score_inc and score_clr asserted together.
- Required response: 0000 next cycle.
REQ-031 Mid-scan reset check:
- Stimulus: SCAN_DIV=4, LZ_BLANK=0, rst pulsed while idx = 2.
- Required response: the next cycle shows digit_en = 1110, num = 0, score 0000.
- digit_en first changes to 1101 exactly 4 cycles after rst deasserts.
